// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA halt arbiter and its picker.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_HALT_WAIT = 2'd1,
    ARB_GRANT     = 2'd2,
    ARB_RELEASE   = 2'd3
  } arb_state_e;

  localparam int unsigned MODE_PRIO = 0;
  localparam int unsigned MODE_RR   = 1;

  // Phase counters hold HALT_LAT / TURN (up to 15); hold counter covers MAX_HOLD.
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HOLD_W = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n > 1) return $clog2(n);
    return 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: lowest set request at or after the start index.
// Start is the pointer in round-robin mode and zero in fixed-priority mode.
module rr_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [idx_w(NUM_CH)-1:0] i_ptr,
  input  logic                     i_mode,
  output logic [idx_w(NUM_CH)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int unsigned IW = idx_w(NUM_CH);

  int unsigned         w_start;
  int unsigned         w_pos;
  int unsigned         w_win;
  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;

  // Rotate the request vector so the search start lands at bit 0, then take the lowest set bit.
  always_comb begin
    w_start = i_mode ? 32'(i_ptr) : 32'd0;
    w_dbl   = {i_req, i_req};
    w_rot   = NUM_CH'(w_dbl >> w_start);
    w_pos   = 0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (w_rot[k] && !o_valid) begin
        o_valid = 1'b1;
        w_pos   = k;
      end
    end
    w_win = w_start + w_pos;
    if (w_win >= NUM_CH) w_win = w_win - NUM_CH;
    o_idx = IW'(w_win);
  end

endmodule

// File: rtl/dma_halt_arbiter.sv
// Multi-master DMA arbiter for the 6502 bus: halts the CPU on pclk1 ticks,
// grants one master at a time, optionally chains grants, and enforces a hold timeout.
module dma_halt_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned HALT_LAT = 1,
  parameter int unsigned TURN     = 1,
  parameter int unsigned MODE     = 0,
  parameter int unsigned CHAIN    = 1,
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     pclk1,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        req,
  input  logic                     clr_timeout,
  output logic [NUM_CH-1:0]        gnt,
  output logic [idx_w(NUM_CH)-1:0] owner,
  output logic                     halt_b,
  output logic                     drive_AB,
  output logic                     timeout
);

  localparam int unsigned IW = idx_w(NUM_CH);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [NUM_CH-1:0] r_gnt;
  logic [NUM_CH-1:0] w_gnt_nxt;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     w_owner_nxt;
  logic              r_halt_b;
  logic              w_halt_b_nxt;
  logic              r_drive;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     w_ptr_nxt;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] w_mask_nxt;
  logic              w_do_grant;

  logic [NUM_CH-1:0] w_req_eff;
  logic [IW-1:0]     w_win;
  logic              w_win_vld;
  logic              w_own_req;
  logic              w_hold_exp;
  logic              w_chain_ok;

  // Channels that timed out stay masked until their request is seen low once.
  assign w_req_eff  = req & ~r_mask;
  assign w_own_req  = |(req & r_gnt);
  assign w_hold_exp = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD - 1));
  assign w_chain_ok = (CHAIN != 0) && enable && w_win_vld;

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .i_req   (w_req_eff),
    .i_ptr   (r_ptr),
    .i_mode  (MODE == MODE_RR),
    .o_idx   (w_win),
    .o_valid (w_win_vld)
  );

  // State and datapath registers; advance only on pclk1 ticks, reset is immediate.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_halt_b  <= 1'b1;
      r_drive   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_ptr     <= '0;
      r_mask    <= '0;
    end else if (pclk1) begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_halt_b  <= w_halt_b_nxt;
      r_drive   <= |w_gnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hold    <= w_hold_nxt;
      r_ptr     <= w_ptr_nxt;
      r_mask    <= w_mask_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (enable && w_win_vld) w_state_nxt = ARB_HALT_WAIT;
      end
      ARB_HALT_WAIT: begin
        if (!w_win_vld)                 w_state_nxt = ARB_RELEASE;
        else if (r_cnt <= CNT_W'(1))    w_state_nxt = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (!w_own_req || w_hold_exp)   w_state_nxt = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        if (r_cnt == '0) w_state_nxt = w_chain_ok ? ARB_GRANT : ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Next values for grant, halt, counters, pointer, mask and sticky timeout.
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_halt_b_nxt  = r_halt_b;
    w_cnt_nxt     = r_cnt;
    w_hold_nxt    = r_hold;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = r_timeout & ~clr_timeout;
    w_mask_nxt    = r_mask & req;
    w_do_grant    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (enable && w_win_vld) begin
          w_halt_b_nxt = 1'b0;
          w_cnt_nxt    = CNT_W'(HALT_LAT);
        end
      end
      ARB_HALT_WAIT: begin
        if (!w_win_vld)              w_cnt_nxt  = '0;
        else if (r_cnt <= CNT_W'(1)) w_do_grant = 1'b1;
        else                         w_cnt_nxt  = r_cnt - CNT_W'(1);
      end
      ARB_GRANT: begin
        w_hold_nxt = r_hold + HOLD_W'(1);
        if (!w_own_req) begin
          w_gnt_nxt = '0;
          w_cnt_nxt = CNT_W'(TURN);
        end else if (w_hold_exp) begin
          w_gnt_nxt     = '0;
          w_cnt_nxt     = CNT_W'(TURN);
          w_timeout_nxt = 1'b1;
          w_mask_nxt    = (r_mask & req) | r_gnt;
        end
      end
      ARB_RELEASE: begin
        if (r_cnt != '0)     w_cnt_nxt    = r_cnt - CNT_W'(1);
        else if (w_chain_ok) w_do_grant   = 1'b1;
        else                 w_halt_b_nxt = 1'b1;
      end
      default: ;
    endcase
    if (w_do_grant) begin
      w_gnt_nxt   = NUM_CH'(1) << w_win;
      w_owner_nxt = w_win;
      w_hold_nxt  = '0;
      if (MODE == MODE_RR) w_ptr_nxt = IW'((32'(w_win) + 32'd1) % NUM_CH);
    end
  end

  assign gnt      = r_gnt;
  assign owner    = r_owner;
  assign halt_b   = r_halt_b;
  assign drive_AB = r_drive;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_dma_halt_arbiter.sv
// Directed bench for dma_halt_arbiter: five parameterisations share clock, pclk1 and reset.
module tb_dma_halt_arbiter;

  logic clk = 1'b0;
  logic pclk1 = 1'b0;
  logic reset = 1'b1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // A: defaults (2 ch, fixed priority, HALT_LAT 1, TURN 1, chain, no hold limit)
  logic [1:0] a_req = '0; logic a_en = 1'b1; logic a_clr = 1'b0;
  logic [1:0] a_gnt; logic [0:0] a_owner; logic a_halt, a_drv, a_to;
  // B: 4 ch fixed priority
  logic [3:0] b_req = '0; logic b_en = 1'b1; logic b_clr = 1'b0;
  logic [3:0] b_gnt; logic [1:0] b_owner; logic b_halt, b_drv, b_to;
  // C: 3 ch round robin
  logic [2:0] c_req = '0; logic c_en = 1'b1; logic c_clr = 1'b0;
  logic [2:0] c_gnt; logic [1:0] c_owner; logic c_halt, c_drv, c_to;
  // D: MAX_HOLD 4
  logic [1:0] d_req = '0; logic d_en = 1'b1; logic d_clr = 1'b0;
  logic [1:0] d_gnt; logic [0:0] d_owner; logic d_halt, d_drv, d_to;
  // E: HALT_LAT 3
  logic [1:0] e_req = '0; logic e_en = 1'b1; logic e_clr = 1'b0;
  logic [1:0] e_gnt; logic [0:0] e_owner; logic e_halt, e_drv, e_to;

  dma_halt_arbiter #(.NUM_CH(2)) u_a (
    .clk_sys(clk), .reset(reset), .pclk1(pclk1), .enable(a_en), .req(a_req),
    .clr_timeout(a_clr), .gnt(a_gnt), .owner(a_owner), .halt_b(a_halt),
    .drive_AB(a_drv), .timeout(a_to));

  dma_halt_arbiter #(.NUM_CH(4), .MODE(0)) u_b (
    .clk_sys(clk), .reset(reset), .pclk1(pclk1), .enable(b_en), .req(b_req),
    .clr_timeout(b_clr), .gnt(b_gnt), .owner(b_owner), .halt_b(b_halt),
    .drive_AB(b_drv), .timeout(b_to));

  dma_halt_arbiter #(.NUM_CH(3), .MODE(1)) u_c (
    .clk_sys(clk), .reset(reset), .pclk1(pclk1), .enable(c_en), .req(c_req),
    .clr_timeout(c_clr), .gnt(c_gnt), .owner(c_owner), .halt_b(c_halt),
    .drive_AB(c_drv), .timeout(c_to));

  dma_halt_arbiter #(.NUM_CH(2), .MAX_HOLD(4)) u_d (
    .clk_sys(clk), .reset(reset), .pclk1(pclk1), .enable(d_en), .req(d_req),
    .clr_timeout(d_clr), .gnt(d_gnt), .owner(d_owner), .halt_b(d_halt),
    .drive_AB(d_drv), .timeout(d_to));

  dma_halt_arbiter #(.NUM_CH(2), .HALT_LAT(3)) u_e (
    .clk_sys(clk), .reset(reset), .pclk1(pclk1), .enable(e_en), .req(e_req),
    .clr_timeout(e_clr), .gnt(e_gnt), .owner(e_owner), .halt_b(e_halt),
    .drive_AB(e_drv), .timeout(e_to));

  // Count one comparison and report it if the observed value differs.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One pclk1 tick followed by one clk_sys cycle with pclk1 low; returns just after that gap edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pclk1 = 1'b1;
      @(posedge clk);
      #1;
      pclk1 = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] e_oh;
    int         exp_order [4];
    exp_order = '{0, 1, 2, 0};

    #22 reset = 1'b0;
    #1;
    chk("rst_gnt",   32'(a_gnt),   32'h0);
    chk("rst_owner", 32'(a_owner), 32'h0);
    chk("rst_halt",  32'(a_halt),  32'h1);
    chk("rst_drv",   32'(a_drv),   32'h0);
    chk("rst_to",    32'(a_to),    32'h0);
    chk("rst_c_own", 32'(c_owner), 32'h0);

    // Single channel, defaults
    a_req = 2'b01; tick();
    chk("t1_halt0", 32'(a_halt), 32'h0);
    chk("t1_gnt0",  32'(a_gnt),  32'h0);
    tick();
    chk("t1_gnt1",  32'(a_gnt),  32'h1);
    chk("t1_drv1",  32'(a_drv),  32'h1);
    chk("t1_own1",  32'(a_owner), 32'h0);
    tick(3);
    chk("t1_gnt4",  32'(a_gnt),  32'h1);
    a_req = 2'b00; tick();
    chk("t1_gnt5",  32'(a_gnt),  32'h0);
    chk("t1_drv5",  32'(a_drv),  32'h0);
    chk("t1_halt5", 32'(a_halt), 32'h0);
    tick();
    chk("t1_halt6", 32'(a_halt), 32'h0);
    tick();
    chk("t1_halt7", 32'(a_halt), 32'h1);

    // Fixed priority, chaining, no preemption, enable drop mid-grant
    b_req = 4'b1010; tick();
    chk("t2_halt0", 32'(b_halt), 32'h0);
    tick();
    chk("t2_gnt1",  32'(b_gnt),   32'h2);
    chk("t2_own1",  32'(b_owner), 32'h1);
    b_en = 1'b0; tick();
    chk("t2_nocut", 32'(b_gnt), 32'h2);
    b_en = 1'b1;
    b_req = 4'b1000; tick();
    chk("t2_gnt3",  32'(b_gnt),  32'h0);
    chk("t2_halt3", 32'(b_halt), 32'h0);
    tick();
    chk("t2_halt4", 32'(b_halt), 32'h0);
    tick();
    chk("t2_gnt5",  32'(b_gnt),   32'h8);
    chk("t2_own5",  32'(b_owner), 32'h3);
    chk("t2_halt5", 32'(b_halt),  32'h0);
    b_req = 4'b1001; tick();
    chk("t2_nopre", 32'(b_gnt), 32'h8);
    b_req = 4'b0001; tick();
    chk("t2_gnt7",  32'(b_gnt), 32'h0);
    tick();
    chk("t2_halt8", 32'(b_halt), 32'h0);
    tick();
    chk("t2_gnt9",  32'(b_gnt),   32'h1);
    chk("t2_own9",  32'(b_owner), 32'h0);
    b_req = 4'b0000; tick(3);
    chk("t2_halt12", 32'(b_halt), 32'h1);

    // Round robin, all requests held, 3-tick transfers
    c_req = 3'b111; tick();
    chk("t3_halt0", 32'(c_halt), 32'h0);
    for (int k = 0; k < 4; k++) begin
      e_oh = 3'b001 << exp_order[k];
      tick();
      chk($sformatf("t3_gnt%0d", k), 32'(c_gnt),   32'(e_oh));
      chk($sformatf("t3_own%0d", k), 32'(c_owner), 32'(exp_order[k]));
      tick(2);
      c_req = (k == 3) ? 3'b000 : (3'b111 & ~e_oh);
      tick();
      chk($sformatf("t3_off%0d", k),  32'(c_gnt),  32'h0);
      chk($sformatf("t3_hold%0d", k), 32'(c_halt), 32'h0);
      c_req = (k == 3) ? 3'b000 : 3'b111;
      tick();
    end
    tick();
    chk("t3_halt_end", 32'(c_halt), 32'h1);

    // Hold timeout, masking, clr_timeout and set-wins
    d_req = 2'b01; tick(2);
    chk("t4_gnt1", 32'(d_gnt), 32'h1);
    tick(3);
    chk("t4_gnt4", 32'(d_gnt), 32'h1);
    tick();
    chk("t4_gnt5", 32'(d_gnt), 32'h0);
    chk("t4_to5",  32'(d_to),  32'h1);
    tick(2);
    chk("t4_halt7", 32'(d_halt), 32'h1);
    tick(2);
    chk("t4_mask_gnt",  32'(d_gnt),  32'h0);
    chk("t4_mask_halt", 32'(d_halt), 32'h1);
    d_req = 2'b00; tick();
    d_req = 2'b01; tick();
    chk("t4_halt11", 32'(d_halt), 32'h0);
    tick();
    chk("t4_gnt12", 32'(d_gnt), 32'h1);
    chk("t4_to12",  32'(d_to),  32'h1);
    d_clr = 1'b1; tick();
    chk("t4_clr", 32'(d_to), 32'h0);
    d_clr = 1'b0; tick(2);
    d_clr = 1'b1; tick();
    chk("t4_gnt16", 32'(d_gnt), 32'h0);
    chk("t4_setwin", 32'(d_to), 32'h1);
    d_clr = 1'b0; d_req = 2'b00; tick(2);
    chk("t4_halt18", 32'(d_halt), 32'h1);

    // HALT_LAT 3 latency, then request withdrawn during halt wait
    e_req = 2'b01; tick();
    chk("t5_halt0", 32'(e_halt), 32'h0);
    tick(2);
    chk("t5_gnt2", 32'(e_gnt), 32'h0);
    tick();
    chk("t5_gnt3", 32'(e_gnt), 32'h1);
    e_req = 2'b00; tick(3);
    chk("t5_halt6", 32'(e_halt), 32'h1);
    e_req = 2'b01; tick();
    chk("t5w_halt0", 32'(e_halt), 32'h0);
    e_req = 2'b00; tick();
    chk("t5w_gnt1", 32'(e_gnt), 32'h0);
    tick();
    chk("t5w_halt2", 32'(e_halt), 32'h1);
    chk("t5w_gnt2",  32'(e_gnt),  32'h0);
    tick(2);
    chk("t5w_gnt4", 32'(e_gnt), 32'h0);

    // enable low blocks halting
    a_en = 1'b0; a_req = 2'b01; tick(3);
    chk("t6_halt", 32'(a_halt), 32'h1);
    chk("t6_gnt",  32'(a_gnt),  32'h0);
    a_en = 1'b1; tick();
    chk("t6_halt_en", 32'(a_halt), 32'h0);
    tick();
    chk("t6_gnt_en", 32'(a_gnt), 32'h1);

    // Asynchronous reset mid-grant with pclk1 low
    chk("t7_to_pre", 32'(d_to), 32'h1);
    reset = 1'b1;
    #1;
    chk("t7_gnt",   32'(a_gnt),   32'h0);
    chk("t7_halt",  32'(a_halt),  32'h1);
    chk("t7_drv",   32'(a_drv),   32'h0);
    chk("t7_owner", 32'(a_owner), 32'h0);
    chk("t7_to",    32'(d_to),    32'h0);
    #2 reset = 1'b0;
    tick();
    chk("t7_rehalt", 32'(a_halt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
